// File: rtl/toll_pkg.sv
// Shared definitions for the toll-lane output arbiter.
//   state_e                : arbiter FSM states
//   HIPASS_W               : width of one lane's hipass code
//   TIMEOUT_CYCLES_DEFAULT : default BUSY cycle limit when TOLL_ARB_TIMEOUT_EN is defined
package toll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam int HIPASS_W               = 4;
  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/toll_rr_pick.sv
// Combinational round-robin picker.
//   req_i    : eligible request vector (already masked)
//   ptr_i    : last served lane; the search starts at ptr_i+1 and wraps
//   valid_o  : at least one eligible request
//   winner_o : index of the chosen lane (0 when valid_o is low)
module toll_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         valid_o,
  output logic [W-1:0] winner_o
);

  logic [W-1:0] idx;

  // Walk the offsets from farthest to nearest so the nearest hit after
  // ptr_i is the last assignment and therefore the one that sticks.
  always_comb begin
    valid_o  = 1'b0;
    winner_o = '0;
    idx      = '0;
    for (int k = N; k >= 1; k--) begin
      idx = W'((int'(ptr_i) + k) % N);
      if (req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/toll_lane_arbiter.sv
// Round-robin arbiter sharing one output stage among NUM_LANES toll lanes.
// Optional feature macro: TOLL_ARB_TIMEOUT_EN (forced release after
// TIMEOUT_CYCLES BUSY cycles, flagged by timeout_err).
//   clk, rst        : clock, synchronous active-high reset
//   lane_req        : level request per lane
//   lane_hipass     : 4-bit hipass code per lane, lane i at [4i+3:4i]
//   out_done        : completion pulse from the output stage (sampled in BUSY only)
//   out_start       : one-cycle start pulse (GRANT cycle)
//   out_lane        : granted lane, stable GRANT..RELEASE
//   out_code        : latched hipass code of the granted lane
//   lane_end_output : one-hot release strobe (RELEASE cycle)
//   busy            : high in GRANT and BUSY
//   served_count    : completed transactions, saturating
//   timeout_err     : pulse in a RELEASE caused by timeout
// Handshake: a lane holds lane_req until it sees its lane_end_output bit;
// the output stage answers each out_start with exactly one out_done pulse.
module toll_lane_arbiter
  import toll_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 2
`ifdef TOLL_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_LANES-1:0]          lane_req,
  input  logic [HIPASS_W*NUM_LANES-1:0] lane_hipass,
  input  logic                          out_done,
  output logic                          out_start,
  output logic [LANE_W-1:0]             out_lane,
  output logic [HIPASS_W-1:0]           out_code,
  output logic [NUM_LANES-1:0]          lane_end_output,
  output logic                          busy,
  output logic [15:0]                   served_count,
  output logic                          timeout_err
);

  state_e                state_q, state_d;
  logic [LANE_W-1:0]     ptr_q, ptr_d;
  logic [NUM_LANES-1:0]  mask_q, mask_d;
  logic [LANE_W-1:0]     out_lane_q, out_lane_d;
  logic [HIPASS_W-1:0]   out_code_q, out_code_d;
  logic                  out_start_q, out_start_d;
  logic [NUM_LANES-1:0]  lane_end_q, lane_end_d;
  logic                  busy_q, busy_d;
  logic [15:0]           served_q, served_d;
  logic                  timeout_q, timeout_d;

  logic                  pick_valid;
  logic [LANE_W-1:0]     pick_winner;
  logic                  to_hit;

  toll_rr_pick #(
    .N (NUM_LANES),
    .W (LANE_W)
  ) u_pick (
    .req_i    (lane_req & ~mask_q),
    .ptr_i    (ptr_q),
    .valid_o  (pick_valid),
    .winner_o (pick_winner)
  );

`ifdef TOLL_ARB_TIMEOUT_EN
  // Counts BUSY cycles; zero on the first BUSY cycle because it is held
  // at zero in every other state.
  logic [7:0] busy_cnt_q, busy_cnt_d;

  always_comb begin
    busy_cnt_d = 8'd0;
    if (state_q == ST_BUSY) busy_cnt_d = busy_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_cnt_q <= 8'd0;
    else     busy_cnt_q <= busy_cnt_d;
  end

  assign to_hit = (state_q == ST_BUSY) && (busy_cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    mask_d      = '0;
    out_lane_d  = out_lane_q;
    out_code_d  = out_code_q;
    served_d    = served_q;
    timeout_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d    = ST_GRANT;
          out_lane_d = pick_winner;
          out_code_d = lane_hipass[int'(pick_winner)*HIPASS_W +: HIPASS_W];
        end
      end
      ST_GRANT: state_d = ST_BUSY;
      ST_BUSY: begin
        // out_done has priority over a timeout landing in the same cycle.
        if (out_done || to_hit) begin
          state_d   = ST_RELEASE;
          timeout_d = !out_done;
          if (served_q != 16'hFFFF) served_d = served_q + 16'd1;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        ptr_d   = out_lane_q;
        // Blocks the released lane for exactly one IDLE cycle so its
        // still-high request cannot win before it drops.
        mask_d  = NUM_LANES'(1) << out_lane_q;
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered outputs are decoded from the next state.
    out_start_d = (state_d == ST_GRANT);
    busy_d      = (state_d == ST_GRANT) || (state_d == ST_BUSY);
    lane_end_d  = '0;
    if (state_d == ST_RELEASE) lane_end_d = NUM_LANES'(1) << out_lane_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= LANE_W'(NUM_LANES - 1);
      mask_q      <= '0;
      out_lane_q  <= '0;
      out_code_q  <= '0;
      out_start_q <= 1'b0;
      lane_end_q  <= '0;
      busy_q      <= 1'b0;
      served_q    <= 16'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      mask_q      <= mask_d;
      out_lane_q  <= out_lane_d;
      out_code_q  <= out_code_d;
      out_start_q <= out_start_d;
      lane_end_q  <= lane_end_d;
      busy_q      <= busy_d;
      served_q    <= served_d;
      timeout_q   <= timeout_d;
    end
  end

  assign out_start       = out_start_q;
  assign out_lane        = out_lane_q;
  assign out_code        = out_code_q;
  assign lane_end_output = lane_end_q;
  assign busy            = busy_q;
  assign served_count    = served_q;
  assign timeout_err     = timeout_q;

endmodule

// File: tb/tb_toll_lane_arbiter.sv
module tb_toll_lane_arbiter;

  localparam int N  = 4;
  localparam int LW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    lane_req;
  logic [4*N-1:0]  lane_hipass;
  logic            out_done;
  logic            out_start;
  logic [LW-1:0]   out_lane;
  logic [3:0]      out_code;
  logic [N-1:0]    lane_end_output;
  logic            busy;
  logic [15:0]     served_count;
  logic            timeout_err;

  int checks = 0;
  int errors = 0;

  // Reference model state: last served lane, lane blocked for the next
  // IDLE decision (-1 = none), completed transaction count.
  int m_ptr, m_mask, m_served;
  bit scramble_req = 1'b0;
  logic [LW-1:0] exp_q[$];

`ifdef TOLL_ARB_TIMEOUT_EN
  toll_lane_arbiter #(.NUM_LANES(N), .LANE_W(LW), .TIMEOUT_CYCLES(8)) dut (
`else
  toll_lane_arbiter #(.NUM_LANES(N), .LANE_W(LW)) dut (
`endif
    .clk(clk), .rst(rst), .lane_req(lane_req), .lane_hipass(lane_hipass),
    .out_done(out_done), .out_start(out_start), .out_lane(out_lane),
    .out_code(out_code), .lane_end_output(lane_end_output), .busy(busy),
    .served_count(served_count), .timeout_err(timeout_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; lane_req = '0; out_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    m_ptr = N - 1; m_mask = -1; m_served = 0;
  endtask

  // Round-robin rule: first requesting, unblocked lane after the last served one.
  function automatic int predict(input logic [N-1:0] req);
    for (int k = 1; k <= N; k++) begin
      int l;
      l = (m_ptr + k) % N;
      if (req[l] && l != m_mask) return l;
    end
    return -1;
  endfunction

  // ---------------- driver ----------------
  // One full transaction: request, grant, `delay` extra BUSY cycles, done,
  // release, first IDLE cycle. Returns granted lane (-1 if none) and the
  // number of IDLE decision cycles spent before the grant.
  task automatic do_txn(input logic [N-1:0] req, input logic [4*N-1:0] hip, input int delay,
                        input bit spur, output int lane, output int waited);
    int w;
    logic [N-1:0] oh;
    lane = -1; waited = 0;
    lane_req = req; lane_hipass = hip; out_done = spur;
    for (int c = 0; c < 3; c++) begin
      if (lane < 0) begin
        w = predict(req);
        tick(); m_mask = -1; waited++;
        checks++;
        if (w < 0) begin
          if ({out_start, busy} !== 2'b00) begin
            errors++; $display("FAIL no_grant: start,busy=%b want 00", {out_start, busy});
          end
        end else begin
          lane = w;
          if ({out_start, busy} !== 2'b11 || out_lane !== LW'(w) || out_code !== hip[4*w +: 4]) begin
            errors++;
            $display("FAIL grant: start,busy=%b lane=%0d code=%h want 11 lane=%0d code=%h",
                     {out_start, busy}, out_lane, out_code, w, hip[4*w +: 4]);
          end
        end
      end
    end
    if (lane < 0) begin
      out_done = 1'b0;
      return;
    end
    out_done = spur;
    if (scramble_req) lane_req = N'($urandom());
    tick();
    out_done = 1'b0;
    checks++;
    if ({out_start, busy} !== 2'b01 || lane_end_output !== '0 || out_lane !== LW'(lane)) begin
      errors++;
      $display("FAIL busy_entry: start,busy=%b end=%b lane=%0d want 01 0000 %0d",
               {out_start, busy}, lane_end_output, out_lane, lane);
    end
    for (int i = 0; i < delay; i++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || lane_end_output !== '0 || out_code !== hip[4*lane +: 4]) begin
        errors++;
        $display("FAIL busy_wait: busy=%b end=%b code=%h want 1 0000 %h",
                 busy, lane_end_output, out_code, hip[4*lane +: 4]);
      end
    end
    out_done = 1'b1;
    tick();
    out_done = 1'b0;
    if (m_served < 65535) m_served++;
    oh = '0; oh[lane] = 1'b1;
    checks++;
    if (lane_end_output !== oh || busy !== 1'b0 || out_start !== 1'b0 || served_count !== 16'(m_served)
        || timeout_err !== 1'b0 || out_lane !== LW'(lane)) begin
      errors++;
      $display("FAIL release: end=%b busy=%b start=%b served=%0d to=%b lane=%0d want %b 0 0 %0d 0 %0d",
               lane_end_output, busy, out_start, served_count, timeout_err, out_lane, oh, m_served, lane);
    end
    m_ptr = lane; m_mask = lane;
    lane_req = req;
    tick();
    checks++;
    if (lane_end_output !== '0 || busy !== 1'b0 || out_start !== 1'b0) begin
      errors++;
      $display("FAIL post_release: end=%b busy=%b start=%b want 0000 0 0", lane_end_output, busy, out_start);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; lane_req = '1; lane_hipass = '1; out_done = 1'b1;
    tick(); tick();
    checks++;
    if ({out_start, busy, timeout_err} !== 3'b000 || out_lane !== '0 || out_code !== 4'h0
        || lane_end_output !== '0 || served_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_values: start,busy,to=%b lane=%0d code=%h end=%b served=%0d want all zero",
               {out_start, busy, timeout_err}, out_lane, out_code, lane_end_output, served_count);
    end
    rst = 1'b0; lane_req = '0; out_done = 1'b0;
    m_ptr = N - 1; m_mask = -1; m_served = 0;
    tick();
    checks++;
    if (out_start !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: start=%b busy=%b want 0 0", out_start, busy);
    end
  endtask

  task automatic test_single();
    int lane, waited;
    do_txn(4'b0010, 16'h0050, 2, 1'b0, lane, waited);
    checks++;
    if (lane !== 1 || out_code !== 4'h5 || served_count !== 16'd1) begin
      errors++;
      $display("FAIL single: lane=%0d code=%h served=%0d want 1 5 1", lane, out_code, served_count);
    end
  endtask

  task automatic test_fairness();
    int lane, waited;
    logic [LW-1:0] e;
    do_reset();
    exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int t = 0; t < 5; t++) begin
      do_txn(4'b1111, 16'($urandom()), $urandom_range(0, 3), 1'b0, lane, waited);
      e = exp_q.pop_front();
      checks++;
      if (lane !== int'(e)) begin
        errors++; $display("FAIL fair_order: grant %0d lane=%0d want %0d", t, lane, e);
      end
    end
    checks++;
    if (served_count !== 16'd5) begin
      errors++; $display("FAIL fair_count: served=%0d want 5", served_count);
    end
  endtask

  task automatic test_mask();
    int lane, waited;
    do_txn(4'b0100, 16'h0A00, 1, 1'b0, lane, waited);
    do_txn(4'b0100, 16'h0300, 0, 1'b0, lane, waited);
    checks++;
    if (lane !== 2 || waited !== 2) begin
      errors++; $display("FAIL mask_regrant: lane=%0d idle_cycles=%0d want 2 2", lane, waited);
    end
  endtask

  task automatic test_spurious();
    int lane, waited;
    lane_req = '0;
    for (int i = 0; i < 3; i++) begin
      out_done = 1'b1;
      tick();
      checks++;
      if (out_start !== 1'b0 || lane_end_output !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL spurious_idle: start=%b end=%b busy=%b want 0 0000 0", out_start, lane_end_output, busy);
      end
    end
    out_done = 1'b0;
    m_mask = -1;
    do_txn(4'b1000, 16'h7000, 3, 1'b1, lane, waited);
    checks++;
    if (lane !== 3) begin
      errors++; $display("FAIL spurious_lane: lane=%0d want 3", lane);
    end
  endtask

  task automatic test_random();
    int lane, waited;
    scramble_req = 1'b1;
    for (int t = 0; t < 40; t++)
      do_txn(N'($urandom_range(0, 15)), 16'($urandom()), $urandom_range(0, 5),
             1'($urandom_range(0, 1)), lane, waited);
    scramble_req = 1'b0;
  endtask

`ifdef TOLL_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int w, lane, waited;
    logic [N-1:0] oh;
    lane_req = '0; out_done = 1'b0;
    tick(); m_mask = -1;
    lane_req = 4'b0001; lane_hipass = 16'($urandom());
    w = predict(4'b0001);
    tick();
    checks++;
    if (out_start !== 1'b1 || out_lane !== LW'(w)) begin
      errors++; $display("FAIL to_grant: start=%b lane=%0d want 1 %0d", out_start, out_lane, w);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || lane_end_output !== '0 || timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL to_wait: busy cycle %0d busy=%b end=%b to=%b want 1 0000 0", i, busy, lane_end_output, timeout_err);
      end
    end
    tick();
    if (m_served < 65535) m_served++;
    oh = '0; oh[w] = 1'b1;
    checks++;
    if (lane_end_output !== oh || timeout_err !== 1'b1 || served_count !== 16'(m_served)) begin
      errors++;
      $display("FAIL to_release: end=%b to=%b served=%0d want %b 1 %0d", lane_end_output, timeout_err, served_count, oh, m_served);
    end
    m_ptr = w; m_mask = w;
    tick();
    checks++;
    if (timeout_err !== 1'b0 || lane_end_output !== '0) begin
      errors++; $display("FAIL to_pulse: to=%b end=%b want 0 0000", timeout_err, lane_end_output);
    end
    // Done on the eighth BUSY cycle coincides with the limit and must win.
    do_txn(4'b0001, 16'($urandom()), 7, 1'b0, lane, waited);
  endtask
`endif

  task automatic test_reset_mid_busy();
    int lane, waited;
    bit started;
    lane_req = 4'b1000; lane_hipass = 16'($urandom()); out_done = 1'b0;
    started = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (!started) begin
        tick();
        if (out_start === 1'b1) started = 1'b1;
      end
    end
    checks++;
    if (!started) begin
      errors++; $display("FAIL mid_start: out_start never seen within 3 cycles, want 1");
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({out_start, busy, timeout_err} !== 3'b000 || out_lane !== '0 || out_code !== 4'h0
        || lane_end_output !== '0 || served_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: start,busy,to=%b lane=%0d code=%h end=%b served=%0d want all zero",
               {out_start, busy, timeout_err}, out_lane, out_code, lane_end_output, served_count);
    end
    rst = 1'b0; lane_req = '0;
    m_ptr = N - 1; m_mask = -1; m_served = 0;
    for (int i = 0; i < 3; i++) begin
      out_done = 1'b1;
      tick();
      checks++;
      if (lane_end_output !== '0 || busy !== 1'b0) begin
        errors++; $display("FAIL mid_no_strobe: end=%b busy=%b want 0000 0", lane_end_output, busy);
      end
    end
    out_done = 1'b0;
    do_txn(4'b1111, 16'($urandom()), 1, 1'b0, lane, waited);
    checks++;
    if (lane !== 0) begin
      errors++; $display("FAIL mid_priority: lane=%0d want 0", lane);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; lane_req = '0; lane_hipass = '0; out_done = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_mask();
    test_spurious();
    test_random();
`ifdef TOLL_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/toll_lane_arbiter.md
# toll_lane_arbiter

Shares one output stage (fare display / barrier driver) among NUM_LANES toll-lane controllers. Each lane raises a request while in its output state, and the arbiter grants lanes round-robin. It forwards the granted lane's hipass code to the output stage, waits for completion, then pulses that lane's end-of-output strobe. It sits between the per-lane FSMs and the single shared output unit.

## Interface
- NUM_LANES, 4: number of requesting lanes, 2..8.
- LANE_W, 2: width of lane index, equal to clog2(NUM_LANES).
- TIMEOUT_CYCLES, 255: maximum BUSY cycles before forced release. Used only with the timeout feature.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- lane_req  in  NUM_LANES  level request, one bit per lane.
- lane_hipass  in  4*NUM_LANES  hipass code per lane; lane i occupies bits [4i+3:4i].
- out_done  in  1  single-cycle completion pulse from the output stage.
- out_start  out  1  single-cycle start pulse to the output stage.
- out_lane  out  LANE_W  granted lane index.
- out_code  out  4  latched hipass code of the granted lane.
- lane_end_output  out  NUM_LANES  one-hot, single-cycle release strobe.
- busy  out  1  high in GRANT and BUSY.
- served_count  out  16  number of completed transactions; saturates at 16'hFFFF.
- timeout_err  out  1  single-cycle pulse on forced release.

## Operation
- FSM states: IDLE, GRANT, BUSY, RELEASE.
- IDLE
  - Eligible set is lane_req & ~mask.
  - If the set is non-empty, the winner is the first set bit searching upward from ptr+1, wrapping modulo NUM_LANES.
  - Latch out_lane ← winner and out_code ← lane_hipass[winner], then go to GRANT.
- GRANT: out_start=1 for exactly one cycle, then go to BUSY.
- BUSY
  - Wait for out_done, then go to RELEASE.
  - lane_req changes are ignored; a started transaction always completes.
- RELEASE
  - lane_end_output[out_lane]=1 for one cycle.
  - ptr ← out_lane.
  - served_count increments unless it is saturated.
  - mask ← one-hot(out_lane) for the next IDLE cycle only, so the released lane cannot be re-granted before its request drops.
  - Next state is IDLE.
- mask clears after one IDLE cycle. A lone requester holding its request is therefore re-granted on the second IDLE cycle.
- out_done is sampled only in BUSY. It is ignored in IDLE, in GRANT, and in the same cycle as out_start.
- out_lane and out_code hold stable from GRANT through RELEASE. They keep their last value in IDLE.
- A request whose lane index is ≥ NUM_LANES cannot occur, by construction.

## Timing
- Reset values:
  - state=IDLE, ptr=NUM_LANES-1 (lane 0 has first priority), mask=0.
  - out_start=0, out_lane=0, out_code=0, lane_end_output=0.
  - busy=0, served_count=0, timeout_err=0.
- Request to start: request seen in IDLE at cycle n → out_start high in cycle n+1.
- Done to release: out_done in cycle m → lane_end_output high in cycle m+1 → IDLE in cycle m+2.
- Minimum transaction is 4 cycles (IDLE, GRANT, BUSY with done, RELEASE).
- rst asserted in any state returns every register to its reset value on the next edge. No strobe is emitted for an aborted transaction.
- All outputs are registered.

## Configuration
- TOLL_ARB_TIMEOUT_EN defined:
  - An 8-bit BUSY cycle counter is cleared on entry to BUSY.
  - If the count reaches TIMEOUT_CYCLES without out_done, the FSM goes to RELEASE as normal and timeout_err pulses in that RELEASE cycle.
  - served_count still increments.
  - If out_done arrives in the same cycle as the limit, it wins and timeout_err stays 0.
- TOLL_ARB_TIMEOUT_EN undefined: BUSY waits indefinitely, timeout_err is tied to 0, and no counter is instantiated.

## Structure
- Shared package toll_pkg holds:
  - the state enum (IDLE, GRANT, BUSY, RELEASE);
  - HIPASS_W=4;
  - the default TIMEOUT_CYCLES constant.
- One sub-module, toll_rr_pick: a combinational round-robin picker.
  - Inputs: req vector and ptr.
  - Outputs: valid and winner index.

## Test plan
- Single lane: lane_req=4'b0010, lane_hipass lane1=4'h5, out_done 3 cycles after out_start.
  - Expect out_start once, out_lane=1, out_code=5, lane_end_output=4'b0010 once, served_count=1.
- Fairness: lane_req=4'b1111 held, out_done each time.
  - Expect grant order 0,1,2,3,0 and exactly one strobe per grant.
- Mask: lane 2 alone holds its request through release.
  - Expect no grant in the first IDLE cycle and a re-grant in the second.
- Spurious done: out_done in IDLE and in the GRANT cycle.
  - Expect both ignored, state stays in BUSY, and no strobe until a BUSY-cycle out_done.
- Timeout (TOLL_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): out_done never asserted.
  - Expect timeout_err and the lane strobe in the same cycle, 8 BUSY cycles after entry, and served_count incremented.
- Reset mid-BUSY.
  - Expect all outputs at reset values next cycle, no lane_end_output, and lane 0 first priority afterwards.
